altair_prg_loader: RTL and testbench

Sequencer that copies a selected built-in program image from program ROM into Altair main RAM when the OSD "Load Program" trigger fires. It holds the CPU in reset for the whole load, takes ownership of the RAM write port from the CPU, streams the image byte by byte with a write/ack handshake, then hands the port back and releases the CPU. It sits between the OSD menu logic and the altair machine's memory subsystem, replacing the ad-hoc prg_sel latch and reset pulse path.

---
 rtl/altair_prg_loader_if.sv | 18 +
 rtl/altair_prg_loader.sv | 196 +++++++++++++++++++
 tb/tb_altair_prg_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/altair_prg_loader_if.sv
// RAM write-port bundle shared by the program loader (master) and the memory mux (slave).
interface altair_prg_loader_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        mem_own;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_own,
    input  mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_own,
    output mem_ack
  );
endinterface

// File: rtl/altair_prg_loader.sv
// Copies a selected program image from ROM into Altair RAM while holding the CPU in reset,
// owning the RAM write port for the duration and handing it back afterwards.
module altair_prg_loader #(
  parameter int unsigned NUM_PRG     = 8,
  parameter int unsigned ROM_AW      = 13,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  localparam int unsigned SEL_W      = (NUM_PRG > 1) ? $clog2(NUM_PRG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_req,
  input  logic [SEL_W-1:0]     prg_sel,
  output logic [SEL_W-1:0]     tbl_idx,
  input  logic [ROM_AW-1:0]    tbl_base,
  input  logic [15:0]          tbl_len,
  input  logic [15:0]          tbl_org,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [7:0]           rom_data,
  altair_prg_loader_if.master  mem,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_FETCH, S_ROMWAIT, S_WRITE, S_RELEASE, S_FIN
  } state_t;

  state_t              state, state_d;
  logic                load_req_q;
  logic [HW-1:0]       hold_cnt, hold_cnt_d;
  logic [AW-1:0]       ack_cnt, ack_cnt_d;
  logic [ROM_AW-1:0]   ptr, ptr_d;
  logic [15:0]         dst, dst_d;
  logic [15:0]         remaining, remaining_d;
  logic [SEL_W-1:0]    tbl_idx_d;
  logic [ROM_AW-1:0]   rom_addr_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_own_q, mem_own_d;
  logic                cpu_reset_d, busy_d, done_d, error_d;
  logic                start_c;

  assign start_c       = load_req & ~load_req_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_own   = mem_own_q;

  // State and datapath registers; reset drops the port and CPU hold immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      load_req_q  <= 1'b0;
      hold_cnt    <= '0;
      ack_cnt     <= '0;
      ptr         <= '0;
      dst         <= '0;
      remaining   <= '0;
      tbl_idx     <= '0;
      rom_addr    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_own_q   <= 1'b0;
      cpu_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      load_req_q  <= load_req;
      hold_cnt    <= hold_cnt_d;
      ack_cnt     <= ack_cnt_d;
      ptr         <= ptr_d;
      dst         <= dst_d;
      remaining   <= remaining_d;
      tbl_idx     <= tbl_idx_d;
      rom_addr    <= rom_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_own_q   <= mem_own_d;
      cpu_reset   <= cpu_reset_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    ack_cnt_d   = ack_cnt;
    ptr_d       = ptr;
    dst_d       = dst;
    remaining_d = remaining;
    tbl_idx_d   = tbl_idx;
    rom_addr_d  = rom_addr;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_own_d   = mem_own_q;
    cpu_reset_d = cpu_reset;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = error;

    unique case (state)
      S_IDLE: begin
        if (start_c) begin
          tbl_idx_d   = prg_sel;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          cpu_reset_d = 1'b1;
          mem_own_d   = 1'b1;
          hold_cnt_d  = HW'(HOLD_CYCLES - 1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) begin
          ptr_d       = tbl_base;
          dst_d       = tbl_org;
          remaining_d = tbl_len;
          if (tbl_len == 16'd0) begin
            mem_own_d  = 1'b0;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            state_d    = S_RELEASE;
          end else begin
            state_d    = S_FETCH;
          end
        end else begin
          hold_cnt_d = hold_cnt - HW'(1);
        end
      end
      S_FETCH: begin
        rom_addr_d = ptr;
        state_d    = S_ROMWAIT;
      end
      S_ROMWAIT: begin
        mem_wdata_d = rom_data;
        mem_addr_d  = dst;
        mem_we_d    = 1'b1;
        ack_cnt_d   = '0;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        if (mem.mem_ack) begin
          mem_we_d    = 1'b0;
          ptr_d       = ptr + ROM_AW'(1);
          dst_d       = dst + 16'd1;
          remaining_d = remaining - 16'd1;
          if (remaining == 16'd1) begin
            mem_own_d  = 1'b0;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            state_d    = S_RELEASE;
          end else begin
            state_d    = S_FETCH;
          end
        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
          // Memory never answered: abandon the image but still release cleanly.
          error_d    = 1'b1;
          mem_we_d   = 1'b0;
          mem_own_d  = 1'b0;
          hold_cnt_d = HW'(HOLD_CYCLES - 1);
          state_d    = S_RELEASE;
        end else begin
          ack_cnt_d = ack_cnt + AW'(1);
        end
      end
      S_RELEASE: begin
        if (hold_cnt == '0) begin
          cpu_reset_d = 1'b0;
          state_d     = S_FIN;
        end else begin
          hold_cnt_d = hold_cnt - HW'(1);
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_altair_prg_loader.sv
// Directed bench for altair_prg_loader: image table + ROM + acking RAM around the DUT,
// with a per-cycle monitor comparing writes and timing against an image-level model.
module tb_altair_prg_loader;

  localparam int unsigned H = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [2:0]  prg_sel;
  logic [2:0]  tbl_idx;
  logic [12:0] tbl_base;
  logic [15:0] tbl_len;
  logic [15:0] tbl_org;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_reset, busy, done, error;

  altair_prg_loader_if mif();

  altair_prg_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .prg_sel(prg_sel),
    .tbl_idx(tbl_idx), .tbl_base(tbl_base), .tbl_len(tbl_len), .tbl_org(tbl_org),
    .rom_addr(rom_addr), .rom_data(rom_data), .mem(mif),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [12:0] base_tab [8];
  logic [15:0] len_tab  [8];
  logic [15:0] org_tab  [8];
  logic [7:0]  rom      [8192];
  logic [7:0]  ram      [65536];

  assign tbl_base = base_tab[tbl_idx];
  assign tbl_len  = len_tab[tbl_idx];
  assign tbl_org  = org_tab[tbl_idx];
  assign rom_data = rom[rom_addr];

  // RAM responder: acks after ack_delay cycles of mem_we, or never when ack_on=0.
  int   ack_delay;
  bit   ack_on;
  int   wcnt;
  assign mif.mem_ack = ack_on && mif.mem_we && (wcnt >= ack_delay);
  always @(posedge clk) begin
    if (mif.mem_we && !mif.mem_ack) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state for the load in progress.
  logic [23:0] exp_q[$];
  logic [15:0] addr_log[$];
  int          rst_cycles, done_cnt, wr_cnt;
  bit          exp_err;
  logic [2:0]  exp_idx;
  bit          prev_we;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_reset) rst_cycles++;
      if (done) begin
        done_cnt++;
        chk("done_error", 32'(error), 32'(exp_err));
        chk("done_idle", {29'd0, busy, cpu_reset, mif.mem_own}, 32'd0);
        chk("done_tbl_idx", 32'(tbl_idx), 32'(exp_idx));
      end
      if (mif.mem_we) begin
        chk("we_implies_own_rst", {30'd0, mif.mem_own, cpu_reset}, 32'd3);
        if (prev_we)
          chk("we_stable", {8'd0, mif.mem_addr, mif.mem_wdata}, {8'd0, prev_addr, prev_wdata});
        if (mif.mem_ack) begin
          if (exp_q.size() == 0) chk("unexpected_write", 32'(mif.mem_addr), 32'hFFFF_FFFF);
          else chk("write", 32'({mif.mem_addr, mif.mem_wdata}), 32'(exp_q.pop_front()));
          ram[mif.mem_addr] = mif.mem_wdata;
          addr_log.push_back(mif.mem_addr);
          wr_cnt++;
        end
      end
      prev_we    = mif.mem_we;
      prev_addr  = mif.mem_addr;
      prev_wdata = mif.mem_wdata;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic prep(input int idx, input int dly, input bit ack, input bit err);
    exp_q.delete();
    addr_log.delete();
    rst_cycles = 0; done_cnt = 0; wr_cnt = 0;
    ack_delay = dly; ack_on = ack; exp_err = err; exp_idx = 3'(idx);
    if (ack)
      for (int i = 0; i < int'(len_tab[idx]); i++)
        exp_q.push_back({16'(org_tab[idx] + 16'(i)), rom[13'(base_tab[idx] + 13'(i))]});
  endtask

  task automatic run_load(input int idx, input int dly, input bit ack, input bit poke);
    int  exp_rst, exp_wr;
    bit  finished;
    prep(idx, dly, ack, !ack && len_tab[idx] != 0);
    if (!ack && len_tab[idx] != 0) begin
      exp_rst = 2*H + 2 + 255; exp_wr = 0;
    end else begin
      exp_rst = 2*H + int'(len_tab[idx]) * (3 + dly); exp_wr = int'(len_tab[idx]);
    end
    prg_sel  = 3'(idx);
    load_req = 1'b1;
    finished = 1'b0;
    for (int i = 0; i < 2000 && !finished; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("start_state", {28'd0, error, busy, cpu_reset, mif.mem_own}, 32'h7);
      if (poke && i == 6) load_req = 1'b0;
      if (poke && i == 9) load_req = 1'b1;
      if (done_cnt > 0) finished = 1'b1;
    end
    if (!finished) chk("done_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'(exp_wr));
    chk("reset_cycles", 32'(rst_cycles), 32'(exp_rst));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_after", {29'd0, busy, mif.mem_we, error}, {31'd0, exp_err});
    load_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 8'((i * 7 + 3) ^ (i >> 8));
    rom[13'h0100] = 8'h3E; rom[13'h0101] = 8'h01; rom[13'h0102] = 8'hD3; rom[13'h0103] = 8'hFF;
    base_tab = '{13'h0000, 13'h0200, 13'h0100, 13'h1FFE, 13'h0300, 13'h0400, 13'h0500, 13'h0600};
    len_tab  = '{16'd1,    16'd3,    16'd4,    16'd4,    16'd2,    16'd0,    16'd5,    16'd3};
    org_tab  = '{16'h0010, 16'h4000, 16'h0000, 16'hFFFE, 16'h5000, 16'h6000, 16'h7000, 16'h8000};
    reset = 1'b0; load_req = 1'b0; prg_sel = 3'd0; ack_on = 1'b1; ack_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {26'd0, mif.mem_we, mif.mem_own, cpu_reset, busy, done, error}, 32'd0);
    chk("reset_addr", {mif.mem_addr, 3'd0, rom_addr}, 32'd0);
    chk("reset_misc", {21'd0, tbl_idx, mif.mem_wdata}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Image 2, ack in the same cycle.
    run_load(2, 0, 1'b1, 1'b0);
    chk("ram0", 32'(ram[0]), 32'h3E);
    chk("ram1", 32'(ram[1]), 32'h01);
    chk("ram2", 32'(ram[2]), 32'hD3);
    chk("ram3", 32'(ram[3]), 32'hFF);
    chk("img2_rst_literal", 32'(rst_cycles), 32'd44);

    // Zero-length image.
    run_load(5, 0, 1'b1, 1'b0);
    chk("len0_rst_literal", 32'(rst_cycles), 32'd32);

    // RAM and ROM address wrap.
    run_load(3, 0, 1'b1, 1'b0);
    chk("wrap_addr0", 32'(addr_log[0]), 32'hFFFE);
    chk("wrap_addr1", 32'(addr_log[1]), 32'hFFFF);
    chk("wrap_addr2", 32'(addr_log[2]), 32'h0000);
    chk("wrap_addr3", 32'(addr_log[3]), 32'h0001);

    // Slow memory.
    run_load(1, 5, 1'b1, 1'b0);
    chk("slow_rst_literal", 32'(rst_cycles), 32'd56);

    // No ack: timeout, sticky error, then cleared by the next load.
    run_load(4, 0, 1'b0, 1'b0);
    chk("timeout_rst_literal", 32'(rst_cycles), 32'd289);
    chk("error_sticky", 32'(error), 32'd1);
    run_load(2, 0, 1'b1, 1'b0);

    // Reset in the middle of writing byte 2.
    prep(6, 2, 1'b1, 1'b0);
    prg_sel = 3'd6; load_req = 1'b1;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(posedge clk); #1;
        if (wr_cnt == 2 && mif.mem_we) hit = 1'b1;
      end
      if (!hit) chk("mid_reset_reach", 32'd0, 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_ctrl", {26'd0, mif.mem_we, mif.mem_own, cpu_reset, busy, done, error}, 32'd0);
    chk("mid_reset_addr", {mif.mem_addr, 3'd0, rom_addr}, 32'd0);
    chk("mid_reset_misc", {21'd0, tbl_idx, mif.mem_wdata}, 32'd0);
    chk("mid_reset_partial", 32'(ram[16'h7001]), 32'(rom[13'h0501]));
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Second load_req edge while busy must not restart.
    run_load(7, 1, 1'b1, 1'b1);
    chk("poke_rst_literal", 32'(rst_cycles), 32'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
